// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand bypass selection and hazard control: per-port forwarding selects,
// load-use and MDU (HI/LO) stalls, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
   parameter int unsigned NREAD   = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned MDU_LAT = 32,
   parameter int unsigned CNTW    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREAD*AW-1:0]   src_flat,
   input  logic [NREAD-1:0]      src_use,
   input  logic [AW-1:0]         rdEX,
   input  logic                  GPRWrEX,
   input  logic                  lwEX,
   input  logic [AW-1:0]         rdMEM,
   input  logic                  GPRWrMEM,
   input  logic                  lwMEM,
   input  logic [AW-1:0]         rdWB,
   input  logic                  GPRWrWB,
   input  logic                  mdu_start,
   input  logic                  mdu_use,
   input  logic                  clr_cnt,
   output logic [NREAD*3-1:0]    sel_flat,
   output logic                  stall,
   output logic                  flush_ex,
   output logic                  mdu_busy,
   output logic [CNTW-1:0]       stall_cnt
);

   localparam int unsigned MCW = $clog2(MDU_LAT + 1);

   localparam logic [2:0] SelOrigin  = 3'd0;
   localparam logic [2:0] SelBusCEX  = 3'd1;
   localparam logic [2:0] SelBusCMEM = 3'd2;
   localparam logic [2:0] SelOutMEM  = 3'd3;
   localparam logic [2:0] SelBusW    = 3'd4;

   logic [AW-1:0]   srcArr [NREAD];
   logic            luh;
   logic            mh;
   logic [MCW-1:0]  mduCnt_q, mduCnt_d;
   logic [CNTW-1:0] stallCnt_q, stallCnt_d;

   always_comb begin
      for (int i = 0; i < NREAD; i++) begin
         srcArr[i] = src_flat[i*AW +: AW];
      end
   end

   always_comb begin
      luh = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         if (src_use[i] && (srcArr[i] != '0) && (srcArr[i] == rdEX) && GPRWrEX && lwEX) begin
            luh = 1'b1;
         end
      end
   end

   assign mdu_busy = (mduCnt_q != '0);
   assign mh       = mdu_busy & (mdu_use | mdu_start);
   assign stall    = luh | mh;
   assign flush_ex = stall;

   // A stalled instruction must not consume forwarded data; every port falls back to Origin.
   always_comb begin
      sel_flat = '0;
      for (int i = 0; i < NREAD; i++) begin
         if (!stall && src_use[i] && (srcArr[i] != '0)) begin
            if ((srcArr[i] == rdEX) && GPRWrEX && !lwEX) begin
               sel_flat[i*3 +: 3] = SelBusCEX;
            end else if ((srcArr[i] == rdMEM) && GPRWrMEM) begin
               sel_flat[i*3 +: 3] = lwMEM ? SelOutMEM : SelBusCMEM;
            end else if ((srcArr[i] == rdWB) && GPRWrWB) begin
               sel_flat[i*3 +: 3] = SelBusW;
            end else begin
               sel_flat[i*3 +: 3] = SelOrigin;
            end
         end
      end
   end

   always_comb begin
      mduCnt_d = mduCnt_q;
      if (mdu_start && !stall) begin
         mduCnt_d = MCW'(MDU_LAT);
      end else if (mduCnt_q != '0) begin
         mduCnt_d = mduCnt_q - MCW'(1);
      end
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (clr_cnt) begin
         stallCnt_d = '0;
      end else if (stall && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mduCnt_q   <= '0;
         stallCnt_q <= '0;
      end else begin
         mduCnt_q   <= mduCnt_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: driver pushes reference expectations per cycle,
// monitor pops and compares at the falling edge.
module tb_fwd_hazard_unit;

   localparam int unsigned NREAD = 2;
   localparam int unsigned AW    = 5;
   localparam int unsigned LAT   = 4;
   localparam int unsigned CNTW  = 4;
   localparam int          CMAX  = (1 << CNTW) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREAD*AW-1:0] src_flat = '0;
   logic [NREAD-1:0]    src_use = '0;
   logic [AW-1:0]       rdEX = '0, rdMEM = '0, rdWB = '0;
   logic                GPRWrEX = 0, lwEX = 0, GPRWrMEM = 0, lwMEM = 0, GPRWrWB = 0;
   logic                mdu_start = 0, mdu_use = 0, clr_cnt = 0;
   logic [NREAD*3-1:0]  sel_flat;
   logic                stall, flush_ex, mdu_busy;
   logic [CNTW-1:0]     stall_cnt;

   fwd_hazard_unit #(.NREAD(NREAD), .AW(AW), .MDU_LAT(LAT), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .src_flat(src_flat), .src_use(src_use),
      .rdEX(rdEX), .GPRWrEX(GPRWrEX), .lwEX(lwEX),
      .rdMEM(rdMEM), .GPRWrMEM(GPRWrMEM), .lwMEM(lwMEM),
      .rdWB(rdWB), .GPRWrWB(GPRWrWB),
      .mdu_start(mdu_start), .mdu_use(mdu_use), .clr_cnt(clr_cnt),
      .sel_flat(sel_flat), .stall(stall), .flush_ex(flush_ex),
      .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [AW-1:0] src0, src1;
      logic [1:0]    use2;
      logic [AW-1:0] rEX, rMEM, rWB;
      logic          wEX, lEX, wMEM, lMEM, wWB;
      logic          start, use_, clr;
   } stim_t;

   typedef struct {
      int cyc;
      int sel0, sel1, stl, flush, busy, cnt;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   failures = 0;

   // Reference state: absolute cycle numbers rather than a down-counter.
   int mCyc = 0;
   int mBusyEnd = -1;
   int mCnt = 0;

   function automatic stim_t idle();
      stim_t s;
      s.src0 = '0; s.src1 = '0; s.use2 = '0;
      s.rEX = '0; s.rMEM = '0; s.rWB = '0;
      s.wEX = 0; s.lEX = 0; s.wMEM = 0; s.lMEM = 0; s.wWB = 0;
      s.start = 0; s.use_ = 0; s.clr = 0;
      return s;
   endfunction

   function automatic int refSel(logic [AW-1:0] src, logic u, stim_t s);
      if (!u || src == 0) return 0;
      if (src == s.rEX && s.wEX && !s.lEX) return 1;
      if (src == s.rMEM && s.wMEM) return s.lMEM ? 3 : 2;
      if (src == s.rWB && s.wWB) return 4;
      return 0;
   endfunction

   function automatic exp_t calcExp(stim_t s);
      exp_t e;
      bit busy, luh, st;
      busy = (mCyc <= mBusyEnd);
      luh = (s.use2[0] && s.src0 != 0 && s.src0 == s.rEX && s.wEX && s.lEX) ||
            (s.use2[1] && s.src1 != 0 && s.src1 == s.rEX && s.wEX && s.lEX);
      st = luh || (busy && (s.use_ || s.start));
      e.cyc   = mCyc;
      e.stl   = st;
      e.flush = st;
      e.busy  = busy;
      e.cnt   = mCnt;
      e.sel0  = st ? 0 : refSel(s.src0, s.use2[0], s);
      e.sel1  = st ? 0 : refSel(s.src1, s.use2[1], s);
      return e;
   endfunction

   task automatic apply(stim_t s);
      src_flat = {s.src1, s.src0}; src_use = s.use2;
      rdEX = s.rEX; GPRWrEX = s.wEX; lwEX = s.lEX;
      rdMEM = s.rMEM; GPRWrMEM = s.wMEM; lwMEM = s.lMEM;
      rdWB = s.rWB; GPRWrWB = s.wWB;
      mdu_start = s.start; mdu_use = s.use_; clr_cnt = s.clr;
   endtask

   task automatic advance(stim_t s, exp_t e);
      if (s.start && !e.stl) mBusyEnd = mCyc + LAT;
      if (s.clr) mCnt = 0;
      else if (e.stl && mCnt < CMAX) mCnt++;
      mCyc++;
   endtask

   task automatic step(stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      apply(s);
      e = calcExp(s);
      expQ.push_back(e);
      advance(s, e);
   endtask

   task automatic check(string name, int act, int exp, int cyc);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("sel0", int'(sel_flat[2:0]), e.sel0, e.cyc);
            check("sel1", int'(sel_flat[5:3]), e.sel1, e.cyc);
            check("stall", int'(stall), e.stl, e.cyc);
            check("flush_ex", int'(flush_ex), e.flush, e.cyc);
            check("mdu_busy", int'(mdu_busy), e.busy, e.cyc);
            check("stall_cnt", int'(stall_cnt), e.cnt, e.cyc);
         end
      end
   end

   // Driver
   initial begin
      stim_t s;
      exp_t  e;
      #15 rst_n = 1'b1;

      step(idle());

      // Forwarding priority
      s = idle(); s.src0 = 5; s.use2 = 2'b01; s.rEX = 5; s.rMEM = 5; s.rWB = 5;
      s.wEX = 1; s.wMEM = 1; s.wWB = 1;
      step(s);
      s.wEX = 0; step(s);
      s.lMEM = 1; step(s);

      // Register 0 and an unused port
      s = idle(); s.src0 = 0; s.use2 = 2'b01; s.rEX = 0; s.wEX = 1;
      step(s);
      s = idle(); s.src1 = 7; s.use2 = 2'b00; s.rEX = 7; s.wEX = 1;
      step(s);

      // Load-use, then the load sits in MEM
      s = idle(); s.src1 = 9; s.use2 = 2'b10; s.rEX = 9; s.wEX = 1; s.lEX = 1;
      step(s);
      s = idle(); s.src1 = 9; s.use2 = 2'b10; s.rMEM = 9; s.wMEM = 1; s.lMEM = 1;
      step(s);

      // MDU latency with a second start held while busy
      s = idle(); s.start = 1; step(s);
      s = idle(); s.use_ = 1; step(s);
      s.start = 1; step(s); step(s); step(s); step(s);
      s = idle(); s.use_ = 1; step(s); step(s);

      // Asynchronous reset between edges while busy
      @(posedge clk);
      #1;
      s = idle(); s.use_ = 1;
      apply(s);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", int'(mdu_busy), 0, mCyc);
      check("rst_cnt", int'(stall_cnt), 0, mCyc);
      #2 rst_n = 1'b1;
      mBusyEnd = -1; mCnt = 0;
      e = calcExp(s);
      expQ.push_back(e);
      advance(s, e);
      step(s);

      // Saturation, then clear while stalled
      s = idle(); s.src0 = 3; s.use2 = 2'b01; s.rEX = 3; s.wEX = 1; s.lEX = 1;
      for (int i = 0; i < 20; i++) step(s);
      s.clr = 1; step(s);
      s.clr = 0; step(s);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         s.src0 = AW'($urandom_range(0, 3)); s.src1 = AW'($urandom_range(0, 3));
         s.use2 = 2'($urandom_range(0, 3));
         s.rEX = AW'($urandom_range(0, 3)); s.rMEM = AW'($urandom_range(0, 3));
         s.rWB = AW'($urandom_range(0, 3));
         s.wEX = 1'($urandom_range(0, 1)); s.lEX = ($urandom_range(0, 3) == 0);
         s.wMEM = 1'($urandom_range(0, 1)); s.lMEM = 1'($urandom_range(0, 1));
         s.wWB = 1'($urandom_range(0, 1));
         s.start = ($urandom_range(0, 7) == 0); s.use_ = ($urandom_range(0, 3) == 0);
         s.clr = ($urandom_range(0, 15) == 0);
         step(s);
      end

      step(idle());
      @(negedge clk);
      @(negedge clk);
      if (expQ.size() != 0) begin
         failures++;
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding selector, serving NREAD decode-stage source ports.
- Generates per-port bypass selects with EX > MEM > WB priority, and never forwards register 0.
- Detects load-use hazards and emits a one-cycle stall/bubble.
- Tracks the in-flight multi-cycle MDU (mult/div) operation with a latency counter, stalling HI/LO consumers until it completes.
- Keeps a saturating stall-cycle performance counter. Sits between decode and the EX operand muxes.

Parameters:
NREAD, 2, number of source-register read ports checked (>=1)
AW, 5, register address width
MDU_LAT, 32, MDU busy cycles after issue (>=1)
CNTW, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
src_flat  in  NREAD*AW  source register numbers; port i at bits [i*AW +: AW]
src_use  in  NREAD  port i actually reads its register
rdEX  in  AW  EX-stage destination
GPRWrEX  in  1  EX writes GPR
lwEX  in  1  EX instruction is a load
rdMEM  in  AW  MEM-stage destination
GPRWrMEM  in  1  MEM writes GPR
lwMEM  in  1  MEM instruction is a load
rdWB  in  AW  WB-stage destination
GPRWrWB  in  1  WB writes GPR
mdu_start  in  1  decode instruction issues a mult/div
mdu_use  in  1  decode instruction reads HI/LO
clr_cnt  in  1  synchronous clear of stall counter
sel_flat  out  NREAD*3  bypass select per port: 0 Origin, 1 busCEX, 2 busCMEM, 3 outMEM, 4 busW
stall  out  1  hold PC and IF/ID
flush_ex  out  1  insert bubble into ID/EX
mdu_busy  out  1  MDU operation in flight
stall_cnt  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): mdu counter=0, mdu_busy=0, stall_cnt=0. A reset mid-operation aborts the MDU operation immediately.
- Combinational outputs (sel_flat, stall, flush_ex) follow their inputs in all states. mdu_busy is a function of state only.

Per-port select, port i with src s:
- If src_use[i]=0 or s=0: Origin.
- Else, first match in this order:
  - s==rdEX & GPRWrEX & !lwEX: busCEX
  - s==rdMEM & GPRWrMEM & !lwMEM: busCMEM
  - s==rdMEM & GPRWrMEM & lwMEM: outMEM
  - s==rdWB & GPRWrWB: busW
  - otherwise: Origin
- When stall=1, all selects are forced to Origin.

Load-use hazard:
- luh = OR over i of (src_use[i] & src_i!=0 & src_i==rdEX & GPRWrEX & lwEX).
- Zero-cycle detect; exactly one bubble per load, because next cycle the load is in MEM and the consumer takes outMEM.

MDU hazard:
- mh = mdu_busy & (mdu_use | mdu_start).

Stall outputs:
- stall = luh | mh.
- flush_ex = stall.

MDU counter (width clog2(MDU_LAT+1)):
- mdu_start & !stall: counter loaded with MDU_LAT.
- Otherwise, if counter != 0: decrement by 1.
- mdu_busy = (counter != 0).
- Timing: an issue accepted at edge t gives mdu_busy high for cycles t+1 .. t+MDU_LAT. A consumer presented at t+MDU_LAT+1 does not stall.
- mdu_start while busy is held by stall and accepted on the first cycle busy is low.
- mdu_start and mdu_use in the same idle cycle: no stall; start accepted.

Stall counter:
- clr_cnt has priority: stall_cnt <= 0.
- Else, if stall=1 and stall_cnt != all-ones: increment.
- Saturates at 2^CNTW-1 and never wraps.

Test Plan:
- Forwarding priority:
  - Stimulus: src0=5, src_use=01; rdEX=rdMEM=rdWB=5, all GPRWr=1, lw=0.
  - Response: sel0=1, stall=0.
  - Then deassert GPRWrEX → sel0=2; then set lwMEM=1 → sel0=3.
- Register 0 and unused ports:
  - Stimulus: src0=0, rdEX=0, GPRWrEX=1; separately src1=7=rdEX with src_use[1]=0.
  - Response: sel0=0 and sel1=0, stall=0.
- Load-use:
  - Stimulus: src1=9, src_use=10, rdEX=9, GPRWrEX=1, lwEX=1.
  - Response: stall=flush_ex=1 and sel1=0 for one cycle.
  - Next cycle, with rdMEM=9, lwMEM=1, EX bubble: sel1=3, stall=0. stall_cnt increments by 1.
- MDU latency (MDU_LAT=4):
  - Stimulus: mdu_start at cycle 0, then mdu_use held high.
  - Response: mdu_busy=1 in cycles 1–4 with stall=1; cycle 5 stall=0. A second mdu_start at cycle 2 is accepted at cycle 5.
- Reset mid-division:
  - Stimulus: rst_n low for 3 ns during busy (asynchronous, between edges).
  - Response: mdu_busy and stall_cnt drop to 0 immediately; mdu_use after release → no stall.
- Counter saturation (CNTW=4):
  - Stimulus: hold a load-use hazard 20 cycles.
  - Response: stall_cnt stops at 15. Then clr_cnt=1 with stall=1 → 0 on the next edge.
